// File: rtl/weight_update.sv
// Parameter store for a small 2-3-2 network: holds 17 weights/biases and, on request,
// applies one gradient step per cycle through a single shared subtract/saturate datapath.
module weight_update #(
   parameter int ETA_SHIFT = 4
) (
   input  logic        clk,
   input  logic        res,
   input  logic        update_start,
   input  logic [15:0] cap_delta_w3_11,
   input  logic [15:0] cap_delta_w3_21,
   input  logic [15:0] cap_delta_w3_31,
   input  logic [15:0] cap_delta_w3_12,
   input  logic [15:0] cap_delta_w3_22,
   input  logic [15:0] cap_delta_w3_32,
   input  logic [15:0] cap_delta_w2_11,
   input  logic [15:0] cap_delta_w2_21,
   input  logic [15:0] cap_delta_w2_12,
   input  logic [15:0] cap_delta_w2_22,
   input  logic [15:0] cap_delta_w2_13,
   input  logic [15:0] cap_delta_w2_23,
   input  logic [15:0] cap_delta_b3_1,
   input  logic [15:0] cap_delta_b3_2,
   input  logic [15:0] cap_delta_b2_1,
   input  logic [15:0] cap_delta_b2_2,
   input  logic [15:0] cap_delta_b2_3,
   input  logic        load_en,
   input  logic [4:0]  load_addr,
   input  logic [15:0] load_data,
   output logic [15:0] w3_11,
   output logic [15:0] w3_21,
   output logic [15:0] w3_31,
   output logic [15:0] w3_12,
   output logic [15:0] w3_22,
   output logic [15:0] w3_32,
   output logic [15:0] w2_11,
   output logic [15:0] w2_21,
   output logic [15:0] w2_12,
   output logic [15:0] w2_22,
   output logic [15:0] w2_13,
   output logic [15:0] w2_23,
   output logic [15:0] b3_1,
   output logic [15:0] b3_2,
   output logic [15:0] b2_1,
   output logic [15:0] b2_2,
   output logic [15:0] b2_3,
   output logic        update_busy,
   output logic        update_done
);

   typedef enum logic [1:0] {IDLE, UPD, DONE} state_t;

   localparam logic [4:0] LAST_IDX = 5'd16;

   state_t             r_state, w_next;
   logic [4:0]         r_idx;
   logic               r_done;
   logic [15:0]        r_p    [17];
   logic [15:0]        r_snap [17];
   logic [15:0]        w_cap  [17];
   logic signed [15:0] w_cur, w_step;
   logic signed [16:0] w_diff;
   logic [15:0]        w_sat;

   assign w_cap[0]  = cap_delta_w3_11;
   assign w_cap[1]  = cap_delta_w3_21;
   assign w_cap[2]  = cap_delta_w3_31;
   assign w_cap[3]  = cap_delta_w3_12;
   assign w_cap[4]  = cap_delta_w3_22;
   assign w_cap[5]  = cap_delta_w3_32;
   assign w_cap[6]  = cap_delta_w2_11;
   assign w_cap[7]  = cap_delta_w2_21;
   assign w_cap[8]  = cap_delta_w2_12;
   assign w_cap[9]  = cap_delta_w2_22;
   assign w_cap[10] = cap_delta_w2_13;
   assign w_cap[11] = cap_delta_w2_23;
   assign w_cap[12] = cap_delta_b3_1;
   assign w_cap[13] = cap_delta_b3_2;
   assign w_cap[14] = cap_delta_b2_1;
   assign w_cap[15] = cap_delta_b2_2;
   assign w_cap[16] = cap_delta_b2_3;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (update_start) w_next = UPD;
         UPD:     if (r_idx == LAST_IDX) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Shared datapath: 17-bit difference, overflow detected where the two top bits disagree
   always_comb begin
      w_cur  = $signed(r_p[r_idx]);
      w_step = $signed(r_snap[r_idx]) >>> ETA_SHIFT;
      w_diff = {w_cur[15], w_cur} - {w_step[15], w_step};
      if (w_diff[16] != w_diff[15])
         w_sat = w_diff[16] ? 16'h8000 : 16'h7FFF;
      else
         w_sat = w_diff[15:0];
   end

   always_ff @(posedge clk) begin
      if (res) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_done  <= 1'b0;
         for (int i = 0; i < 17; i++) begin
            r_p[i]    <= '0;
            r_snap[i] <= '0;
         end
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == DONE);
         case (r_state)
            IDLE: begin
               // A start in the same cycle as a load takes precedence; the load is dropped
               if (update_start) begin
                  for (int i = 0; i < 17; i++) r_snap[i] <= w_cap[i];
                  r_idx <= '0;
               end else if (load_en && load_addr <= LAST_IDX) begin
                  r_p[load_addr] <= load_data;
               end
            end
            UPD: begin
               r_p[r_idx] <= w_sat;
               r_idx      <= r_idx + 5'd1;
            end
            default: ;
         endcase
      end
   end

   assign update_busy = (r_state == UPD);
   assign update_done = r_done;

   assign w3_11 = r_p[0];
   assign w3_21 = r_p[1];
   assign w3_31 = r_p[2];
   assign w3_12 = r_p[3];
   assign w3_22 = r_p[4];
   assign w3_32 = r_p[5];
   assign w2_11 = r_p[6];
   assign w2_21 = r_p[7];
   assign w2_12 = r_p[8];
   assign w2_22 = r_p[9];
   assign w2_13 = r_p[10];
   assign w2_23 = r_p[11];
   assign b3_1  = r_p[12];
   assign b3_2  = r_p[13];
   assign b2_1  = r_p[14];
   assign b2_2  = r_p[15];
   assign b2_3  = r_p[16];

endmodule

// File: tb/tb_weight_update.sv
// Randomized self-checking bench for weight_update against an array-based reference model.
module tb_weight_update;

   localparam int ETA = 4;

   logic        clk = 1'b0;
   logic        res = 1'b1;
   logic        update_start = 1'b0;
   logic        load_en = 1'b0;
   logic [4:0]  load_addr = '0;
   logic [15:0] load_data = '0;
   logic [15:0] cap [17];
   logic [15:0] prm [17];
   logic        update_busy, update_done;

   int mp [17];
   int ms [17];
   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   weight_update #(.ETA_SHIFT(ETA)) dut (
      .clk(clk), .res(res), .update_start(update_start),
      .cap_delta_w3_11(cap[0]),  .cap_delta_w3_21(cap[1]),  .cap_delta_w3_31(cap[2]),
      .cap_delta_w3_12(cap[3]),  .cap_delta_w3_22(cap[4]),  .cap_delta_w3_32(cap[5]),
      .cap_delta_w2_11(cap[6]),  .cap_delta_w2_21(cap[7]),  .cap_delta_w2_12(cap[8]),
      .cap_delta_w2_22(cap[9]),  .cap_delta_w2_13(cap[10]), .cap_delta_w2_23(cap[11]),
      .cap_delta_b3_1(cap[12]),  .cap_delta_b3_2(cap[13]),
      .cap_delta_b2_1(cap[14]),  .cap_delta_b2_2(cap[15]),  .cap_delta_b2_3(cap[16]),
      .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
      .w3_11(prm[0]), .w3_21(prm[1]), .w3_31(prm[2]), .w3_12(prm[3]), .w3_22(prm[4]),
      .w3_32(prm[5]), .w2_11(prm[6]), .w2_21(prm[7]), .w2_12(prm[8]), .w2_22(prm[9]),
      .w2_13(prm[10]), .w2_23(prm[11]), .b3_1(prm[12]), .b3_2(prm[13]),
      .b2_1(prm[14]), .b2_2(prm[15]), .b2_3(prm[16]),
      .update_busy(update_busy), .update_done(update_done)
   );

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int sx(input logic [15:0] v);
      return int'($signed(v));
   endfunction

   // One learning step: floor division by 2^ETA, subtract, clamp to the 16-bit signed range
   function automatic int step(input int p, input int d);
      int s, q, r;
      s = 1 << ETA;
      q = d / s;
      if (d < 0 && (d % s) != 0) q = q - 1;
      r = p - q;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      for (int i = 0; i < 17; i++)
         chk($sformatf("%s_p%0d", tag, i), prm[i], 16'(mp[i]));
   endtask

   task automatic load(input int addr, input logic [15:0] data);
      load_en   = 1'b1;
      load_addr = 5'(addr);
      load_data = data;
      tick();
      load_en = 1'b0;
      if (addr < 17) mp[addr] = sx(data);
      check_all("load");
   endtask

   task automatic do_reset();
      res = 1'b1;
      tick();
      tick();
      res = 1'b0;
      for (int i = 0; i < 17; i++) mp[i] = 0;
   endtask

   // disturb: re-pulse start, attempt a load and scramble the deltas while the update runs
   task automatic run_update(input string tag, input bit disturb, input bit coload);
      for (int i = 0; i < 17; i++) ms[i] = sx(cap[i]);
      update_start = 1'b1;
      if (coload) begin
         load_en   = 1'b1;
         load_addr = 5'($urandom_range(0, 16));
         load_data = 16'($urandom);
      end
      tick();
      update_start = 1'b0;
      load_en      = 1'b0;
      chk({tag, "_busy0"}, 16'(update_busy), 16'd1);
      chk({tag, "_done0"}, 16'(update_done), 16'd0);
      check_all({tag, "_k0"});
      for (int k = 1; k <= 19; k++) begin
         if (disturb && k == 2)
            for (int i = 0; i < 17; i++) cap[i] = 16'($urandom);
         if (disturb && k == 5) update_start = 1'b1;
         if (disturb && k == 6) begin
            load_en   = 1'b1;
            load_addr = 5'($urandom_range(0, 16));
            load_data = 16'($urandom);
         end
         tick();
         update_start = 1'b0;
         load_en      = 1'b0;
         if (k <= 17) mp[k-1] = step(mp[k-1], ms[k-1]);
         chk($sformatf("%s_busy%0d", tag, k), 16'(update_busy), 16'(k < 17));
         chk($sformatf("%s_done%0d", tag, k), 16'(update_done), 16'(k == 18));
         check_all($sformatf("%s_k%0d", tag, k));
      end
   endtask

   initial begin
      for (int i = 0; i < 17; i++) cap[i] = '0;
      do_reset();
      chk("rst_busy", 16'(update_busy), 16'd0);
      chk("rst_done", 16'(update_done), 16'd0);
      check_all("rst");

      // basic: 0x0400 - (0x0100 >>> 4) = 0x03F0
      load(0, 16'h0400);
      cap[0] = 16'h0100;
      run_update("basic", 1'b0, 1'b0);
      chk("basic_w3_11", prm[0], 16'h03F0);

      // negative deltas on the last bias
      cap[0] = 16'h0000;
      load(16, 16'h0400);
      cap[16] = 16'hFF00;
      run_update("negb", 1'b0, 1'b0);
      chk("negb_b2_3", prm[16], 16'h0410);
      load(16, 16'h0400);
      cap[16] = 16'hFFFF;
      run_update("neg1", 1'b0, 1'b0);
      chk("neg1_b2_3", prm[16], 16'h0401);

      // saturation in both directions
      cap[16] = 16'h0000;
      load(6, 16'h7FF0);
      load(7, 16'h8005);
      cap[6] = 16'h8000;
      cap[7] = 16'h7FFF;
      run_update("sat", 1'b0, 1'b0);
      chk("sat_hi", prm[6], 16'h7FFF);
      chk("sat_lo", prm[7], 16'h8000);

      // protocol violations during the run, then start+load collision
      for (int i = 0; i < 17; i++) cap[i] = 16'($urandom);
      run_update("proto", 1'b1, 1'b0);
      run_update("coload", 1'b0, 1'b1);

      // unused load addresses and random rounds
      for (int r = 0; r < 6; r++) begin
         for (int j = 0; j < 4; j++) load($urandom_range(0, 31), 16'($urandom));
         for (int i = 0; i < 17; i++) begin
            case ($urandom_range(0, 3))
               0:       cap[i] = 16'h8000;
               1:       cap[i] = 16'h7FFF;
               default: cap[i] = 16'($urandom);
            endcase
         end
         run_update($sformatf("rnd%0d", r), r[0], 1'b0);
      end

      // reset partway through an update
      for (int i = 0; i < 17; i++) begin
         load(i, 16'($urandom));
         cap[i] = 16'($urandom);
      end
      for (int i = 0; i < 17; i++) ms[i] = sx(cap[i]);
      update_start = 1'b1;
      tick();
      update_start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         mp[k-1] = step(mp[k-1], ms[k-1]);
         check_all($sformatf("mid_k%0d", k));
      end
      res = 1'b1;
      tick();
      res = 1'b0;
      for (int i = 0; i < 17; i++) mp[i] = 0;
      chk("mid_busy", 16'(update_busy), 16'd0);
      check_all("mid_rst");
      for (int k = 0; k < 12; k++) begin
         tick();
         chk($sformatf("mid_done%0d", k), 16'(update_done), 16'd0);
         chk($sformatf("mid_idle%0d", k), 16'(update_busy), 16'd0);
      end
      for (int i = 0; i < 17; i++) load(i, 16'($urandom));
      run_update("post", 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/weight_update.md
WEIGHT_UPDATE -- requirements
Module: weight_update

Interface
REQ-001 Parameter ETA_SHIFT, default 4, learning rate as arithmetic right shift (eta = 2^-ETA_SHIFT), legal range 0..15.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 res  input  1  reset, synchronous, active-high.
REQ-004 update_start  input  1  one-cycle request to apply accumulated deltas.
REQ-005 cap_delta_w3_ij (ij=11,21,31,12,22,32)  input  16 each  accumulated dC/dw3, signed Q6.10.
REQ-006 cap_delta_w2_ij (ij=11,21,12,22,13,23)  input  16 each  accumulated dC/dw2, signed Q6.10.
REQ-007 cap_delta_b3_j (j=1,2), cap_delta_b2_i (i=1,2,3)  input  16 each  accumulated bias deltas, signed Q6.10.
REQ-008 load_en  input  1  write load_data into parameter at load_addr.
REQ-009 load_addr  input  5  parameter index, map per REQ-013.
REQ-010 load_data  input  16  initial parameter value, signed Q6.10.
REQ-011 w3_ij, w2_ij, b3_j, b2_i (same index sets as REQ-005..007)  output  16 each  current parameters, driven directly from registers.
REQ-012 update_busy  output  1  high while update sequence runs; update_done  output  1  one-cycle completion pulse.

Function
REQ-013 Index map: 0..5 = w3_11,21,31,12,22,32; 6..11 = w2_11,21,12,22,13,23; 12..13 = b3_1,2; 14..16 = b2_1,2,3; 17..31 unused.
REQ-014 FSM states IDLE, UPD, DONE; IDLE->UPD on update_start; UPD->DONE after index 16 written; DONE->IDLE unconditionally after one cycle.
REQ-015 On the edge accepting update_start (IDLE only), all 17 cap_delta inputs SHALL be captured into a snapshot register bank and the index counter cleared to 0.
REQ-016 In UPD, exactly one parameter per cycle, index 0..16 ascending: p <= sat16(p - (snap[idx] >>> ETA_SHIFT)).
REQ-017 Arithmetic: shift arithmetic (sign-extending, truncation toward -inf); subtraction at 17 bits; result >0x7FFF clamps to 0x7FFF, < -0x8000 clamps to 0x8000.
REQ-018 Timing: start sampled at edge T; parameter idx updated at edge T+1+idx; update_done high for the cycle after edge T+18 (i.e. set at T+18, cleared at T+19).
REQ-019 update_busy high from edge T through edge T+18 exclusive of DONE cycle, i.e. during the 17 UPD cycles only; low in IDLE and DONE.
REQ-020 Only one shared subtract/saturate datapath SHALL exist; parameters not at the current index hold value.
REQ-021 Inputs cap_delta_* changing after acceptance SHALL NOT affect the running update.
REQ-022 update_start while in UPD or DONE SHALL be ignored (not queued).
REQ-023 load_en in IDLE writes load_data to load_addr on that edge; load_addr 17..31 ignored; load_en in UPD or DONE ignored.
REQ-024 load_en and update_start both high in IDLE: update_start wins, load discarded.
REQ-025 Parameter outputs change only on load or UPD write edges; visible in the cycle after the write.

Reset
REQ-026 res high on an edge: all 17 parameters, snapshot bank and index counter to 0, FSM to IDLE, update_busy=0, update_done=0.
REQ-027 res has priority over update_start and load_en; reset mid-UPD aborts with no update_done pulse and partial results discarded (all parameters 0).

Verification
REQ-028 Reset: assert res 2 cycles -> all parameter outputs 0x0000, update_busy=0, update_done=0.
REQ-029 Basic: load w3_11=0x0400, cap_delta_w3_11=0x0100, start at T -> w3_11=0x03F0 after edge T+1, busy for 17 cycles, update_done single pulse set at T+18.
REQ-030 Negative delta / bias: load b2_3=0x0400, cap_delta_b2_3=0xFF00 -> b2_3=0x0410 after edge T+17; cap_delta=0xFFFF -> shift gives 0xFFFF, result 0x0401.
REQ-031 Saturation: w2_11=0x7FF0 with delta 0x8000 -> 0x7FFF; w2_21=0x8005 with delta 0x7FFF -> 0x8000.
REQ-032 Protocol: start pulsed again at T+5, load_en at T+6, cap_delta inputs changed at T+2 -> results equal snapshot values, exactly one done pulse, loaded address unchanged.
REQ-033 Reset mid-op: res at edge T+9 -> all parameters 0, IDLE next cycle, no update_done; subsequent start runs full 17-cycle sequence normally.
